// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage
//   ReLU + 2x2 stride-2 max-pool + unsigned 8-bit requantisation on a
//   raster-scanned AXI-Stream feature map.
//
// Ports
//   axi_clk, axi_reset_n      clock, async active-low reset
//   i_data_valid/i_data       slave stream, 24-bit signed conv result
//   o_data_ready              slave tready
//   o_data_valid/o_data       master stream, 8-bit unsigned pooled pixel
//   o_data_last               master tlast, last pooled pixel of a frame
//   i_data_ready              master tready
//   o_frame_done              1-cycle pulse after the last input beat of a frame
module relu_maxpool_stage #(
  parameter int IMG_WIDTH  = 510,
  parameter int IMG_HEIGHT = 510,
  parameter int SHIFT      = 8
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        i_data_valid,
  input  logic [23:0] i_data,
  output logic        o_data_ready,
  output logic        o_data_valid,
  output logic [7:0]  o_data,
  output logic        o_data_last,
  input  logic        i_data_ready,
  output logic        o_frame_done
);

  localparam int PW  = IMG_WIDTH / 2;
  localparam int PH  = IMG_HEIGHT / 2;
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int LAW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ACT_LAST = CW'(2 * PW - 1);
  localparam logic [RW-1:0] ROW_ACT_LAST = RW'(2 * PH - 1);
  localparam bit            ODD_W        = (IMG_WIDTH % 2) == 1;
  localparam bit            ODD_H        = (IMG_HEIGHT % 2) == 1;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [22:0]    pair_q;
  logic [22:0]    relu;
  logic [22:0]    pool_h;   // horizontal pair max
  logic [22:0]    lb_rd;
  logic [22:0]    pool_m;   // full 2x2 window max
  logic [22:0]    quot;
  logic [7:0]     sat;
  logic [LAW-1:0] lb_addr;
  logic           accept;
  logic           active;
  logic           pool_load;

  // Even-row horizontal maxima, consumed by the following odd row.
  logic [22:0] line_buf [PW];

  // Input stalls only while a result is parked in the output register.
  assign o_data_ready = !(o_data_valid && !i_data_ready);
  assign accept       = i_data_valid && o_data_ready;

  assign relu    = i_data[23] ? '0 : i_data[22:0];
  // Only an odd trailing column/row can fall outside the pooling region.
  assign active  = !(ODD_W && (col == COL_LAST)) && !(ODD_H && (row == ROW_LAST));
  assign lb_addr = LAW'(col >> 1);

  assign pool_h = (relu > pair_q) ? relu : pair_q;
  assign lb_rd  = line_buf[lb_addr];
  assign pool_m = (lb_rd > pool_h) ? lb_rd : pool_h;

  assign quot = pool_m >> SHIFT;
  assign sat  = (|quot[22:8]) ? 8'hFF : quot[7:0];

  assign pool_load = accept && active && col[0] && row[0];

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      col          <= '0;
      row          <= '0;
      pair_q       <= '0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_data_last  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= accept && (col == COL_LAST) && (row == ROW_LAST);

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (active && !col[0])
          pair_q <= relu;
      end

      // A new result can only land when the register is empty or draining,
      // because ready gating blocks the accept otherwise.
      if (pool_load) begin
        o_data_valid <= 1'b1;
        o_data       <= sat;
        o_data_last  <= (col == COL_ACT_LAST) && (row == ROW_ACT_LAST);
      end else if (i_data_ready) begin
        o_data_valid <= 1'b0;
      end
    end
  end

  // Write row and read row always differ in parity, so no read-during-write.
  always_ff @(posedge axi_clk) begin
    if (accept && active && col[0] && !row[0])
      line_buf[lb_addr] <= pool_h;
  end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// tb_relu_maxpool_stage
//   Three instances run side by side: 4x4/SHIFT=0, 4x4/SHIFT=8, 5x5/SHIFT=0.
//   A window-level reference model (2-D pixel array, max of four, shift,
//   clamp) predicts every pooled output, tlast and frame-done pulse.
module tb_relu_maxpool_stage;

  localparam int NI = 3;

  logic              axi_clk = 1'b0;
  logic              axi_reset_n = 1'b0;
  logic [NI-1:0]     iv, irdy, ordy, ovld, olast, ofd;
  logic [23:0]       idat [NI];
  logic [7:0]        odat [NI];

  always #5 axi_clk = ~axi_clk;

  relu_maxpool_stage #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .SHIFT(0)) u_dut0 (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .i_data_valid(iv[0]), .i_data(idat[0]), .o_data_ready(ordy[0]),
    .o_data_valid(ovld[0]), .o_data(odat[0]), .o_data_last(olast[0]),
    .i_data_ready(irdy[0]), .o_frame_done(ofd[0]));

  relu_maxpool_stage #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .SHIFT(8)) u_dut1 (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .i_data_valid(iv[1]), .i_data(idat[1]), .o_data_ready(ordy[1]),
    .o_data_valid(ovld[1]), .o_data(odat[1]), .o_data_last(olast[1]),
    .i_data_ready(irdy[1]), .o_frame_done(ofd[1]));

  relu_maxpool_stage #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .SHIFT(0)) u_dut2 (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .i_data_valid(iv[2]), .i_data(idat[2]), .o_data_ready(ordy[2]),
    .o_data_valid(ovld[2]), .o_data(odat[2]), .o_data_last(olast[2]),
    .i_data_ready(irdy[2]), .o_frame_done(ofd[2]));

  function automatic int w_of(input int g); return (g == 2) ? 5 : 4; endfunction
  function automatic int h_of(input int g); return (g == 2) ? 5 : 4; endfunction
  function automatic int s_of(input int g); return (g == 1) ? 8 : 0; endfunction

  // reference model state
  logic [22:0] pix  [NI][5][5];
  logic [23:0] src  [NI][$];
  logic [8:0]  expq [NI][$];   // {last, data}
  logic [7:0]  got  [NI][$];
  int          nbeat [NI];
  bit          fd_exp [NI], must_vld [NI], stall_prev [NI], acc [NI];
  logic [7:0]  held_d [NI];
  logic        held_l [NI];
  int          bp_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input int g, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s inst%0d: observed %0h expected %0h", tag, g, obs, exp_v);
    end
  endtask

  task automatic chk_seq(input string tag, input int g, input int e0, input int e1,
                         input int e2, input int e3);
    int ev [4];
    ev = '{e0, e1, e2, e3};
    chk({tag, "_count"}, g, got[g].size(), 4);
    for (int i = 0; i < 4 && i < got[g].size(); i++) chk(tag, g, got[g][i], ev[i]);
    got[g].delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_valid"}, g, ovld[g], 0);
      chk({tag, "_data"},  g, odat[g], 0);
      chk({tag, "_last"},  g, olast[g], 0);
      chk({tag, "_fdone"}, g, ofd[g], 0);
    end
  endtask

  function automatic logic [22:0] max2(input logic [22:0] a, input logic [22:0] b);
    return (a > b) ? a : b;
  endfunction

  // One accepted beat: place it in the frame picture; close a window when
  // its bottom-right pixel arrives.
  task automatic model_beat(input int g, input logic [23:0] d);
    int r, c, aw, ah;
    logic [22:0] m, q;
    r  = nbeat[g] / w_of(g);
    c  = nbeat[g] % w_of(g);
    aw = (w_of(g) / 2) * 2;
    ah = (h_of(g) / 2) * 2;
    pix[g][r][c] = d[23] ? 23'd0 : d[22:0];
    if ((r % 2 == 1) && (c % 2 == 1) && r < ah && c < aw) begin
      m = max2(max2(pix[g][r-1][c-1], pix[g][r-1][c]), max2(pix[g][r][c-1], pix[g][r][c]));
      q = m >> s_of(g);
      expq[g].push_back({(r == ah - 1) && (c == aw - 1), (q > 23'd255) ? 8'hFF : q[7:0]});
      must_vld[g] = 1'b1;
    end
    fd_exp[g] = (nbeat[g] == w_of(g) * h_of(g) - 1);
    nbeat[g]  = (nbeat[g] + 1) % (w_of(g) * h_of(g));
  endtask

  function automatic logic [23:0] rnd_pix();
    logic [23:0] v;
    v = 24'($urandom);
    case ($urandom_range(0, 3))
      0:       return v | 24'h800000;
      1:       return 24'($urandom_range(0, 300));
      2:       return v & 24'h00FFFF;
      default: return v;
    endcase
  endfunction

  // mode 0: downstream always ready, no gaps; 1: random gaps and ready;
  // 2: inst0 downstream stalls for 10 cycles once its first output appears.
  task automatic run_phase(input int maxc, input int mode);
    int cyc;
    bit busy;
    logic [8:0] e;
    cyc    = 0;
    busy   = 1'b1;
    bp_cnt = 0;
    for (int g = 0; g < NI; g++) irdy[g] = (mode == 2 && g == 0) ? 1'b0 : 1'b1;
    while (busy && cyc < maxc) begin
      @(negedge axi_clk);
      for (int g = 0; g < NI; g++) begin
        chk("frame_done", g, ofd[g], fd_exp[g]);
        if (must_vld[g]) chk("latency", g, ovld[g], 1);
        if (stall_prev[g]) begin
          chk("hold_data", g, odat[g], held_d[g]);
          chk("hold_last", g, olast[g], held_l[g]);
        end
        chk("in_ready", g, ordy[g], !(ovld[g] && !irdy[g]));
        if (mode == 2 && g == 0 && ovld[0] && bp_cnt < 10) begin
          chk("bp_data", 0, odat[0], 6);
          bp_cnt++;
        end
        if (ovld[g] && irdy[g]) begin
          chk("pending", g, expq[g].size() > 0, 1);
          if (expq[g].size() > 0) begin
            e = expq[g].pop_front();
            chk("data", g, odat[g], e[7:0]);
            chk("last", g, olast[g], e[8]);
          end
          got[g].push_back(odat[g]);
        end
        fd_exp[g]   = 1'b0;
        must_vld[g] = 1'b0;
        acc[g]      = iv[g] && ordy[g];
        if (acc[g]) begin
          model_beat(g, idat[g]);
          void'(src[g].pop_front());
        end
        stall_prev[g] = ovld[g] && !irdy[g];
        held_d[g]     = odat[g];
        held_l[g]     = olast[g];
      end
      @(posedge axi_clk);
      #1;
      cyc++;
      busy = 1'b0;
      for (int g = 0; g < NI; g++) begin
        if (!iv[g] || acc[g]) begin
          if (src[g].size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
            iv[g]   = 1'b1;
            idat[g] = src[g][0];
          end else begin
            iv[g] = 1'b0;
          end
        end
        if (mode == 1)               irdy[g] = ($urandom_range(0, 3) != 0);
        else if (mode == 2 && g == 0) irdy[g] = (bp_cnt >= 10);
        else                          irdy[g] = 1'b1;
        if (src[g].size() > 0 || expq[g].size() > 0 || iv[g] || ovld[g] || fd_exp[g])
          busy = 1'b1;
      end
    end
    chk("timeout", 0, busy, 0);
  endtask

  task automatic load_ramp(input int g, input int n);
    for (int i = 1; i <= n; i++) src[g].push_back(24'(i));
  endtask

  initial begin
    iv   = '0;
    irdy = '1;
    for (int g = 0; g < NI; g++) begin
      idat[g] = '0; nbeat[g] = 0; fd_exp[g] = 0; must_vld[g] = 0;
      stall_prev[g] = 0; acc[g] = 0;
    end

    // reset state
    repeat (3) @(posedge axi_clk);
    #1;
    chk_reset_outs("rst");
    @(negedge axi_clk) axi_reset_n = 1'b1;
    @(posedge axi_clk);
    #1;

    // ramps and the requantisation window frame
    load_ramp(0, 16);
    load_ramp(2, 25);
    src[1] = '{24'h000000, 24'h012345, 24'hFFFFFB, 24'h000000,
               24'hFFFFFB, 24'h000000, 24'h000000, 24'h00AB00,
               24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000,
               24'h000000, 24'h000000, 24'h000000, 24'h0001FF};
    run_phase(300, 0);
    chk_seq("ramp4", 0, 6, 8, 14, 16);
    chk_seq("shift8", 1, 255, 171, 0, 1);
    chk_seq("ramp5", 2, 7, 9, 17, 19);

    // all-negative frame with one positive pixel
    for (int i = 0; i < 16; i++) src[0].push_back((i == 4) ? 24'h000003 : 24'hFFFFFB);
    run_phase(300, 0);
    chk_seq("relu", 0, 3, 0, 0, 0);

    // downstream backpressure
    load_ramp(0, 16);
    load_ramp(1, 16);
    load_ramp(2, 25);
    run_phase(400, 2);
    chk_seq("bp", 0, 6, 8, 14, 16);
    got[1].delete();
    got[2].delete();

    // reset in the middle of a frame
    for (int g = 0; g < NI; g++) load_ramp(g, 6);
    run_phase(200, 0);
    axi_reset_n = 1'b0;
    iv = '0;
    #2;
    chk_reset_outs("midrst");
    repeat (2) @(posedge axi_clk);
    #1;
    chk_reset_outs("midrst_hold");
    @(negedge axi_clk) axi_reset_n = 1'b1;
    for (int g = 0; g < NI; g++) begin
      nbeat[g] = 0; fd_exp[g] = 0; must_vld[g] = 0; stall_prev[g] = 0; acc[g] = 0;
      expq[g].delete();
      got[g].delete();
    end
    @(posedge axi_clk);
    #1;
    load_ramp(0, 16);
    run_phase(300, 0);
    chk_seq("after_rst", 0, 6, 8, 14, 16);

    // randomised frames with random gaps and backpressure
    for (int g = 0; g < NI; g++)
      for (int i = 0; i < 3 * w_of(g) * h_of(g); i++) src[g].push_back(rnd_pix());
    run_phase(5000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
